// File: rtl/vc_arb_pkg.sv
// rtl/vc_arb_pkg.sv - shared turn encoding, default widths/weights and credit width helper
package vc_arb_pkg;

  typedef enum logic {
    TURN_VC0 = 1'b0,
    TURN_VC1 = 1'b1
  } turn_e;

  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_DS_DEPTH   = 4;
  localparam int DEF_WEIGHT_VC0 = 2;
  localparam int DEF_WEIGHT_VC1 = 1;

  // One extra bit so the counter can hold the full depth value itself.
  function automatic int credit_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_CREDIT_W = credit_w(DEF_DS_DEPTH);

endpackage

// File: rtl/vc_credit_counter.sv
// rtl/vc_credit_counter.sv - downstream credit tracking with sticky overflow flag
module vc_credit_counter
  import vc_arb_pkg::*;
#(
  parameter int ds_depth = DEF_DS_DEPTH,
  localparam int CW = credit_w(ds_depth)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_grant,
  input  logic          i_ds_rd_enable,
  output logic [CW-1:0] o_credits,
  output logic          o_can_issue,
  output logic          o_error_arb
);

  localparam logic [CW-1:0] FULL = CW'(ds_depth);

  logic [CW-1:0] r_credits;
  logic          r_error;

  // A credit returned while already full is an overflow: flag it and saturate.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_credits <= FULL;
      r_error   <= 1'b0;
    end else if (i_grant && !i_ds_rd_enable) begin
      r_credits <= r_credits - CW'(1);
    end else if (!i_grant && i_ds_rd_enable) begin
      if (r_credits == FULL) begin
        r_error <= 1'b1;
      end else begin
        r_credits <= r_credits + CW'(1);
      end
    end
  end

  assign o_credits   = r_credits;
  assign o_can_issue = (r_credits != '0);
  assign o_error_arb = r_error;

endmodule

// File: rtl/vc_rr_arbiter.sv
// rtl/vc_rr_arbiter.sv - weighted round-robin drain of two VC FIFOs into one credited downstream FIFO
module vc_rr_arbiter
  import vc_arb_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int ds_depth   = DEF_DS_DEPTH,
  parameter int weight_vc0 = DEF_WEIGHT_VC0,
  parameter int weight_vc1 = DEF_WEIGHT_VC1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_empty_fifo_vc0,
  input  logic                  i_empty_fifo_vc1,
  input  logic [data_width-1:0] i_data_in_vc0,
  input  logic [data_width-1:0] i_data_in_vc1,
  output logic                  o_rd_enable_vc0,
  output logic                  o_rd_enable_vc1,
  input  logic                  i_ds_rd_enable,
  output logic [data_width-1:0] o_data_out,
  output logic                  o_wr_enable_out,
  output logic                  o_vc_id_out,
  output logic                  o_error_arb
);

  localparam int         CW = credit_w(ds_depth);
  localparam logic [2:0] W0 = 3'(weight_vc0);
  localparam logic [2:0] W1 = 3'(weight_vc1);

  turn_e         r_state;
  turn_e         w_state_nxt;
  logic [2:0]    r_burst;
  logic [2:0]    w_burst_nxt;
  logic [2:0]    w_burst_inc;
  logic          w_grant_vc0;
  logic          w_grant_vc1;
  logic          w_grant;
  logic          w_can_issue;
  logic [CW-1:0] w_credits;
  logic          r_v2;
  logic          r_sel2;

  vc_credit_counter #(
    .ds_depth(ds_depth)
  ) u_credit (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_grant       (w_grant),
    .i_ds_rd_enable(i_ds_rd_enable),
    .o_credits     (w_credits),
    .o_can_issue   (w_can_issue),
    .o_error_arb   (o_error_arb)
  );

  assign w_burst_inc = r_burst + 3'd1;
  assign w_grant     = w_grant_vc0 | w_grant_vc1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= TURN_VC0;
      r_burst <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  // The owner of the turn goes first; the other VC is served when the owner is empty.
  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst;
    w_grant_vc0 = 1'b0;
    w_grant_vc1 = 1'b0;
    if (w_can_issue) begin
      case (r_state)
        TURN_VC0: begin
          if (!i_empty_fifo_vc0) begin
            w_grant_vc0 = 1'b1;
            if (w_burst_inc == W0) begin
              w_state_nxt = TURN_VC1;
              w_burst_nxt = 3'd0;
            end else begin
              w_burst_nxt = w_burst_inc;
            end
          end else if (!i_empty_fifo_vc1) begin
            w_grant_vc1 = 1'b1;
            if (W1 == 3'd1) begin
              w_state_nxt = TURN_VC0;
              w_burst_nxt = 3'd0;
            end else begin
              w_state_nxt = TURN_VC1;
              w_burst_nxt = 3'd1;
            end
          end
        end
        TURN_VC1: begin
          if (!i_empty_fifo_vc1) begin
            w_grant_vc1 = 1'b1;
            if (w_burst_inc == W1) begin
              w_state_nxt = TURN_VC0;
              w_burst_nxt = 3'd0;
            end else begin
              w_burst_nxt = w_burst_inc;
            end
          end else if (!i_empty_fifo_vc0) begin
            w_grant_vc0 = 1'b1;
            if (W0 == 3'd1) begin
              w_state_nxt = TURN_VC1;
              w_burst_nxt = 3'd0;
            end else begin
              w_state_nxt = TURN_VC0;
              w_burst_nxt = 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Grant -> pop strobe -> FIFO data plus delayed select -> registered write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rd_enable_vc0 <= 1'b0;
      o_rd_enable_vc1 <= 1'b0;
      r_v2            <= 1'b0;
      r_sel2          <= 1'b0;
      o_wr_enable_out <= 1'b0;
      o_vc_id_out     <= 1'b0;
      o_data_out      <= '0;
    end else begin
      o_rd_enable_vc0 <= w_grant_vc0;
      o_rd_enable_vc1 <= w_grant_vc1;
      r_v2            <= o_rd_enable_vc0 | o_rd_enable_vc1;
      r_sel2          <= o_rd_enable_vc1;
      o_wr_enable_out <= r_v2;
      o_vc_id_out     <= r_sel2;
      if (!r_v2) begin
        o_data_out <= '0;
      end else if (r_sel2) begin
        o_data_out <= i_data_in_vc1;
      end else begin
        o_data_out <= i_data_in_vc0;
      end
    end
  end

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// tb/tb_vc_rr_arbiter.sv - randomized bench for vc_rr_arbiter against a cycle-indexed reference model
module tb_vc_rr_arbiter;

  localparam int DW    = 6;
  localparam int DEPTH = 4;
  localparam int WV0   = 2;
  localparam int WV1   = 1;
  localparam int NCYC  = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic          e0, e1, ds_rd;
  logic [DW-1:0] d0, d1;
  logic          rd0, rd1, wr, vc, err;
  logic [DW-1:0] dout;

  always #5 clk = ~clk;

  vc_rr_arbiter #(
    .data_width(DW),
    .ds_depth  (DEPTH),
    .weight_vc0(WV0),
    .weight_vc1(WV1)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_empty_fifo_vc0(e0),
    .i_empty_fifo_vc1(e1),
    .i_data_in_vc0   (d0),
    .i_data_in_vc1   (d1),
    .o_rd_enable_vc0 (rd0),
    .o_rd_enable_vc1 (rd1),
    .i_ds_rd_enable  (ds_rd),
    .o_data_out      (dout),
    .o_wr_enable_out (wr),
    .o_vc_id_out     (vc),
    .o_error_arb     (err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Environment VC FIFOs (popped by the DUT strobes) and the model's own copies.
  logic [DW-1:0] q0[$], q1[$], mq0[$], mq1[$];
  logic          prev_rd0 = 1'b0, prev_rd1 = 1'b0, prev_rst = 1'b1;

  // Model: expected outputs indexed by cycle, plus credits / turn owner / run length.
  bit            exp_rd0[NCYC], exp_rd1[NCYC], exp_wr[NCYC], exp_vc[NCYC];
  logic [DW-1:0] exp_d[NCYC];
  int            m_cred = DEPTH;
  int            m_turn = 0;
  int            m_run  = 0;
  bit            m_err  = 1'b0;
  int            obs_g0, obs_g1, obs_wr;

  task automatic pick(output int g);
    int own, oth, w_own, w_oth, n_own, n_oth;
    own   = m_turn;
    oth   = 1 - m_turn;
    w_own = (own == 0) ? WV0 : WV1;
    w_oth = (oth == 0) ? WV0 : WV1;
    n_own = (own == 0) ? mq0.size() : mq1.size();
    n_oth = (oth == 0) ? mq0.size() : mq1.size();
    g = -1;
    if (m_cred == 0) return;
    if (n_own > 0) begin
      g = own;
      m_run++;
      if (m_run >= w_own) begin
        m_turn = oth;
        m_run  = 0;
      end
    end else if (n_oth > 0) begin
      g = oth;
      if (w_oth == 1) begin
        m_run = 0;
      end else begin
        m_turn = oth;
        m_run  = 1;
      end
    end
  endtask

  task automatic tick(input bit rst, input bit pop, input int n0, input int n1);
    logic [DW-1:0] w;
    int g;
    @(negedge clk);
    cyc++;
    chk("rd_enable_vc0", int'(rd0), int'(exp_rd0[cyc]));
    chk("rd_enable_vc1", int'(rd1), int'(exp_rd1[cyc]));
    chk("rd_exclusive", int'(rd0 & rd1), 0);
    chk("wr_enable_out", int'(wr), int'(exp_wr[cyc]));
    if (exp_wr[cyc]) begin
      chk("vc_id_out", int'(vc), int'(exp_vc[cyc]));
      chk("data_out", int'(dout), int'(exp_d[cyc]));
    end
    chk("error_arb", int'(err), int'(m_err));
    chk("credits", int'(dut.w_credits), m_cred);
    obs_g0 += int'(rd0);
    obs_g1 += int'(rd1);
    obs_wr += int'(wr);

    d0 = '0;
    d1 = '0;
    if (!prev_rst) begin
      if (prev_rd0 && q0.size() > 0) d0 = q0.pop_front();
      if (prev_rd1 && q1.size() > 0) d1 = q1.pop_front();
    end
    prev_rd0 = rd0;
    prev_rd1 = rd1;
    prev_rst = rst;

    for (int i = 0; i < n0; i++) begin
      w = DW'($urandom_range(0, 63));
      q0.push_back(w);
      mq0.push_back(w);
    end
    for (int i = 0; i < n1; i++) begin
      w = DW'($urandom_range(0, 63));
      q1.push_back(w);
      mq1.push_back(w);
    end
    // A pop strobe already on the wire counts against the empty flag.
    e0    = (q0.size() - int'(rd0)) <= 0;
    e1    = (q1.size() - int'(rd1)) <= 0;
    ds_rd = pop;
    reset = rst;

    if (rst) begin
      q0.delete(); q1.delete(); mq0.delete(); mq1.delete();
      m_cred = DEPTH; m_turn = 0; m_run = 0; m_err = 1'b0;
      for (int k = cyc + 1; k <= cyc + 3; k++) begin
        exp_rd0[k] = 1'b0; exp_rd1[k] = 1'b0; exp_wr[k] = 1'b0;
      end
    end else begin
      pick(g);
      if (g == 0) begin
        exp_rd0[cyc+1] = 1'b1;
        exp_wr[cyc+3]  = 1'b1;
        exp_vc[cyc+3]  = 1'b0;
        exp_d[cyc+3]   = mq0.pop_front();
      end else if (g == 1) begin
        exp_rd1[cyc+1] = 1'b1;
        exp_wr[cyc+3]  = 1'b1;
        exp_vc[cyc+3]  = 1'b1;
        exp_d[cyc+3]   = mq1.pop_front();
      end
      if (g >= 0 && !pop) begin
        m_cred--;
      end else if (g < 0 && pop) begin
        if (m_cred == DEPTH) m_err = 1'b1;
        else m_cred++;
      end
    end
  endtask

  task automatic clear_obs();
    obs_g0 = 0;
    obs_g1 = 0;
    obs_wr = 0;
  endtask

  initial begin
    bit r, p;
    reset = 1'b1; e0 = 1'b1; e1 = 1'b1; ds_rd = 1'b0; d0 = '0; d1 = '0;
    clear_obs();

    repeat (3) tick(1, 0, 0, 0);
    repeat (10) tick(0, 0, 0, 0);
    chk("idle_no_grants", obs_g0 + obs_g1, 0);
    chk("idle_credits", int'(dut.w_credits), DEPTH);

    clear_obs();
    tick(0, 1, 3, 0);
    repeat (8) tick(0, 1, 0, 0);
    chk("vc0_only_grants", obs_g0, 3);
    chk("vc0_only_writes", obs_wr, 3);

    tick(1, 0, 0, 0);
    clear_obs();
    tick(0, 1, 6, 6);
    repeat (20) tick(0, 1, 0, 0);
    chk("weighted_vc0_grants", obs_g0, 6);
    chk("weighted_vc1_grants", obs_g1, 6);

    tick(1, 0, 0, 0);
    clear_obs();
    tick(0, 0, 6, 6);
    repeat (10) tick(0, 0, 0, 0);
    chk("credit_stall_grants", obs_g0 + obs_g1, DEPTH);
    tick(0, 1, 0, 0);
    repeat (6) tick(0, 0, 0, 0);
    chk("credit_return_grants", obs_g0 + obs_g1, DEPTH + 1);

    tick(1, 0, 0, 0);
    repeat (2) tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    repeat (5) tick(0, 0, 0, 0);
    chk("error_sticky", int'(err), 1);
    chk("error_credits_sat", int'(dut.w_credits), DEPTH);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("error_cleared", int'(err), 0);

    tick(0, 0, 4, 0);
    tick(1, 0, 0, 0);
    clear_obs();
    repeat (8) tick(0, 0, 0, 0);
    chk("reset_drops_inflight", obs_wr, 0);
    chk("reset_credits", int'(dut.w_credits), DEPTH);

    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) == 0);
      p = ((m_cred < DEPTH) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 59) == 0);
      if (r) tick(1, 0, 0, 0);
      else tick(0, p, int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 2) == 0));
    end
    repeat (6) tick(0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
